// File: rtl/display_pkg.sv
// Shared definitions for the double-buffered display frame loader.
package display_pkg;
  localparam int ROWS_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;
endpackage

// File: rtl/row_load_counter.sv
// Row index for back-bank loads: synchronous clear beats enable; terminal flags the last row.
module row_load_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         terminal
);
  // Row count is a power of two, so the last row is all ones.
  assign terminal = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end
endmodule

// File: rtl/frame_swap_scheduler.sv
// Loads each new frame into the back bank row by row, then swaps banks on the display's frame_end.
module frame_swap_scheduler
  import display_pkg::*;
#(
  parameter int ROWS   = ROWS_DEFAULT,
  parameter int DROP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_ready,
  input  logic                    frame_end,
  input  logic                    load_stall,
  output logic                    load_en,
  output logic [$clog2(ROWS)-1:0] load_row,
  output logic                    wr_bank,
  output logic                    front_bank,
  output logic                    swap_pulse,
  output logic                    busy,
  output logic [DROP_W-1:0]       drop_count
);
  localparam int RW = $clog2(ROWS);

  state_t state;
  logic   pending;
  logic   row_last;
  logic   last_write;
  logic   row_clear;
  logic   drop_inc;

  assign load_en    = (state == LOAD) && !load_stall;
  assign busy       = (state != IDLE);
  assign wr_bank    = ~front_bank;
  assign last_write = load_en && row_last;

  // Every entry into LOAD starts from row 0, including back-to-back reloads.
  assign row_clear  = (frame_ready && (state != LOAD)) || last_write;

  // A frame is lost when it displaces a pending one, or replaces an unswapped loaded frame.
  assign drop_inc   = frame_ready &&
                      (((state == LOAD) && pending) || ((state == WAIT_SWAP) && !frame_end));

  row_load_counter #(.W(RW)) u_row (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (row_clear),
    .enable   (load_en),
    .count    (load_row),
    .terminal (row_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= 1'b0;
      front_bank <= 1'b0;
      swap_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      swap_pulse <= 1'b0;
      if (drop_inc && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_W'(1);
      end
      case (state)
        IDLE: begin
          if (frame_ready) state <= LOAD;
        end
        LOAD: begin
          if (last_write) begin
            state   <= (pending || frame_ready) ? LOAD : WAIT_SWAP;
            pending <= 1'b0;
          end else if (frame_ready) begin
            pending <= 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (frame_end) begin
            front_bank <= ~front_bank;
            swap_pulse <= 1'b1;
          end
          if (frame_ready) begin
            state <= LOAD;
          end else if (frame_end) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_swap_scheduler.sv
// Scoreboard bench: a frame-level model predicts row writes and bank swaps; a negedge monitor checks them.
module tb_frame_swap_scheduler;
  localparam int ROWS     = 64;
  localparam int DROP_W   = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              frame_ready;
  logic              frame_end;
  logic              load_stall;
  logic              load_en;
  logic [5:0]        load_row;
  logic              wr_bank;
  logic              front_bank;
  logic              swap_pulse;
  logic              busy;
  logic [DROP_W-1:0] drop_count;

  frame_swap_scheduler #(.ROWS(ROWS), .DROP_W(DROP_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_ready (frame_ready),
    .frame_end   (frame_end),
    .load_stall  (load_stall),
    .load_en     (load_en),
    .load_row    (load_row),
    .wr_bank     (wr_bank),
    .front_bank  (front_bank),
    .swap_pulse  (swap_pulse),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Expected events, tagged with the cycle in which they must appear.
  typedef struct {
    int when;
    int row;
    int bank;
  } ev_t;
  ev_t wq[$];
  ev_t sq[$];

  // Frame-level model: phase 0 = nothing to do, 1 = copying a frame, 2 = frame ready to show.
  int m_phase = 0;
  int m_row = 0;
  bit m_pending = 0;
  int m_front = 0;
  int m_drop = 0;

  int exp_front = 0;
  int exp_drop = 0;
  int exp_busy = 0;

  task automatic model_reset();
    m_phase = 0; m_row = 0; m_pending = 0; m_front = 0; m_drop = 0;
    exp_front = 0; exp_drop = 0; exp_busy = 0;
    wq.delete();
    sq.delete();
  endtask

  task automatic model_step(bit fr, bit fe, bit st);
    bit wr;
    exp_front = m_front;
    exp_drop  = m_drop;
    exp_busy  = (m_phase != 0);
    wr = (m_phase == 1) && !st;
    if (wr) wq.push_back('{cyc, m_row, 1 - m_front});
    case (m_phase)
      0: if (fr) begin m_phase = 1; m_row = 0; end
      1: begin
        if (fr && m_pending) m_drop++;
        if (wr && m_row == ROWS - 1) begin
          if (m_pending || fr) m_row = 0;
          else m_phase = 2;
          m_pending = 0;
        end else begin
          if (wr) m_row++;
          if (fr) m_pending = 1;
        end
      end
      default: begin
        if (fe) begin
          m_front = 1 - m_front;
          sq.push_back('{cyc + 1, 0, m_front});
          m_phase = 0;
        end
        if (fr) begin
          if (!fe) m_drop++;
          m_phase = 1;
          m_row = 0;
        end
      end
    endcase
    if (m_drop > DROP_MAX) m_drop = DROP_MAX;
  endtask

  task automatic tick(bit fr, bit fe, bit st);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame_ready = fr;
    frame_end = fe;
    load_stall = st;
    model_step(fr, fe, st);
  endtask

  task automatic rtick();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    frame_ready = 1'b0;
    frame_end = 1'b0;
    load_stall = 1'b0;
    model_reset();
  endtask

  task automatic idle(int n);
    repeat (n) tick(0, 0, 0);
  endtask

  task automatic wait_phase(int p);
    int n = 0;
    while (m_phase != p && n < 300) begin
      tick(0, 0, 0);
      n++;
    end
    if (m_phase != p) check("wait_phase_timeout", m_phase, p);
  endtask

  task automatic wait_row(int r);
    int n = 0;
    while (!(m_phase == 1 && m_row == r) && n < 300) begin
      tick(0, 0, 0);
      n++;
    end
    if (m_row != r) check("wait_row_timeout", m_row, r);
  endtask

  // Monitor: pops expected events whenever the DUT strobes, and checks the steady outputs.
  always @(negedge clk) begin
    ev_t e;
    check("front_bank", int'(front_bank), exp_front);
    check("wr_bank", int'(wr_bank), 1 - exp_front);
    check("drop_count", int'(drop_count), exp_drop);
    check("busy", int'(busy), exp_busy);
    if (!rst_n) check("load_row_in_reset", int'(load_row), 0);
    if (load_en) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = wq.pop_front();
        check("write_cycle", cyc, e.when);
        check("write_row", int'(load_row), e.row);
        check("write_bank", int'(wr_bank), e.bank);
      end
    end else if (wq.size() != 0 && wq[0].when <= cyc) begin
      e = wq.pop_front();
      check("missing_write_row", -1, e.row);
    end
    if (swap_pulse) begin
      if (sq.size() == 0) begin
        check("unexpected_swap", 1, 0);
      end else begin
        e = sq.pop_front();
        check("swap_cycle", cyc, e.when);
        check("swap_front", int'(front_bank), e.bank);
      end
    end else if (sq.size() != 0 && sq[0].when <= cyc) begin
      e = sq.pop_front();
      check("missing_swap_cycle", -1, e.when);
    end
  end

  initial begin
    rst_n = 1'b0;
    frame_ready = 1'b0;
    frame_end = 1'b0;
    load_stall = 1'b0;
    repeat (3) rtick();

    // Plain load, then swap on frame_end.
    idle(5);
    tick(1, 0, 0);
    wait_phase(2);
    idle(3);
    tick(0, 1, 0);
    idle(2);
    check("front_after_first_swap", int'(front_bank), 1);
    check("wr_after_first_swap", int'(wr_bank), 0);

    // Stall holds the row.
    tick(1, 0, 0);
    wait_row(9);
    repeat (5) begin
      tick(0, 0, 1);
      check("row_held_in_stall", int'(load_row), 9);
    end
    wait_phase(2);
    tick(0, 1, 0);
    idle(2);

    // Pending frame plus one dropped frame during a single load.
    tick(1, 0, 0);
    wait_row(30);
    tick(1, 0, 0);
    idle(4);
    tick(1, 0, 0);
    wait_phase(2);
    tick(0, 1, 0);
    idle(2);

    // frame_ready and frame_end together while waiting to swap.
    tick(1, 0, 0);
    wait_phase(2);
    tick(1, 1, 0);
    wait_phase(2);
    tick(0, 1, 0);
    idle(2);

    // Reset in the middle of a load.
    tick(1, 0, 0);
    wait_row(40);
    repeat (3) rtick();
    idle(20);
    check("front_after_abort", int'(front_bank), 0);
    tick(1, 0, 0);
    wait_phase(2);
    tick(0, 1, 0);
    idle(2);

    // Randomized traffic, including frame_end outside the swap window.
    for (int i = 0; i < 3000; i++) begin
      bit fr, fe, st;
      fr = ($urandom_range(0, 99) < 3);
      fe = (m_phase == 2) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 9) < 2);
      tick(fr, fe, st);
    end
    wait_phase(2);
    tick(0, 1, 0);
    idle(2);

    // Repeated replacement of an unswapped frame saturates the drop counter.
    tick(1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      wait_phase(2);
      tick(1, 0, 0);
    end
    wait_phase(2);
    idle(2);
    check("drop_saturated", int'(drop_count), DROP_MAX);
    tick(0, 1, 0);
    idle(5);

    check("writes_outstanding", wq.size(), 0);
    check("swaps_outstanding", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
